// File: rtl/key_pkg.sv
// Shared definitions for the key one-hot capture block: FSM encoding,
// default debounce length and a population-count helper.
package key_pkg;

   localparam int KEY_W            = 8;
   localparam int DEBOUNCE_DEFAULT = 16;

   typedef enum logic [1:0] {
      WAIT_RELEASE = 2'b00,
      WAIT_PRESS   = 2'b01,
      HOLD         = 2'b10
   } key_state_e;

   function automatic logic [3:0] bit_count(input logic [KEY_W-1:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < KEY_W; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/vec_debounce.sv
// Per-bit 2-flop synchronizer followed by a whole-vector debounce counter.
// stable is high only while p has held one value long enough to be trusted.
module vec_debounce
   import key_pkg::*;
#(
   parameter int W               = KEY_W,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] key_in,
   output logic [W-1:0] p,
   output logic         stable
);

   localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES);

   logic [W-1:0] meta;
   logic [W-1:0] s;
   logic [7:0]   cnt;

   // stable is registered and requires s == p on the same edge, so it can
   // never be high in the cycle where p takes a new value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta   <= '0;
         s      <= '0;
         p      <= '0;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep meta -> s -> p a true shift
         // chain; blocking ones would collapse it into a single flop.
         meta   <= key_in;
         s      <= meta;
         p      <= s;
         stable <= (s == p) && (cnt == CNT_MAX);
         if (s != p) begin
            cnt <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/key_onehot_capture.sv
// Captures a debounced single-key press as a one-hot event, holds it until
// the downstream stage accepts it, and counts accepted presses.
module key_onehot_capture
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] key_in,
   input  logic             out_ready,
   output logic [KEY_W-1:0] onehot_out,
   output logic             out_valid,
   output logic             multi_err,
   output logic [7:0]       press_count
);

   key_state_e       state;
   key_state_e       state_next;
   logic [KEY_W-1:0] p;
   logic             stable;
   logic [3:0]       ones;
   logic             capture;
   logic             multi_det;
   logic             accept;

   vec_debounce #(
      .W               (KEY_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .key_in (key_in),
      .p      (p),
      .stable (stable)
   );

   assign ones = bit_count(p);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= WAIT_RELEASE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      // NOTE: default first so every path assigns state_next and no latch
      // is inferred.
      state_next = state;
      case (state)
         WAIT_RELEASE: begin
            if (stable && (p == '0)) state_next = WAIT_PRESS;
         end
         WAIT_PRESS: begin
            if (stable && (ones == 4'd1))      state_next = HOLD;
            else if (stable && (ones > 4'd1))  state_next = WAIT_RELEASE;
         end
         HOLD: begin
            if (out_valid && out_ready) state_next = WAIT_RELEASE;
         end
         default: state_next = WAIT_RELEASE;
      endcase
   end

   always_comb begin
      capture   = 1'b0;
      multi_det = 1'b0;
      accept    = 1'b0;
      case (state)
         WAIT_PRESS: begin
            capture   = stable && (ones == 4'd1);
            multi_det = stable && (ones > 4'd1);
         end
         HOLD:    accept = out_valid && out_ready;
         default: ;
      endcase
   end

   // All outputs are flops; out_ready only ever reaches them through accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         onehot_out  <= '0;
         out_valid   <= 1'b0;
         multi_err   <= 1'b0;
         press_count <= '0;
      end else begin
         multi_err <= multi_det;
         if (capture) begin
            onehot_out <= p;
            out_valid  <= 1'b1;
         end else if (accept) begin
            out_valid   <= 1'b0;
            press_count <= press_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_key_onehot_capture.sv
// Directed self-checking bench for key_onehot_capture with DEBOUNCE_CYCLES = 4.
module tb_key_onehot_capture;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] key_in;
   logic       out_ready;
   logic [7:0] onehot_out;
   logic       out_valid;
   logic       multi_err;
   logic [7:0] press_count;

   int errors = 0;
   int checks = 0;

   key_onehot_capture #(.DEBOUNCE_CYCLES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in),
      .out_ready   (out_ready),
      .onehot_out  (onehot_out),
      .out_valid   (out_valid),
      .multi_err   (multi_err),
      .press_count (press_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and land 1 time unit after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int budget);
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < budget) begin
         tick(1);
         n++;
      end
      check("valid_within_budget", 8'(out_valid), 8'h01);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] one;
      logic [7:0] exp;
      logic       seen;
      one       = 8'h01;
      rst       = 1'b1;
      key_in    = 8'h00;
      out_ready = 1'b0;
      #2;
      check("reset_onehot", onehot_out, 8'h00);
      check("reset_valid", 8'(out_valid), 8'h00);
      check("reset_multi", 8'(multi_err), 8'h00);
      check("reset_count", press_count, 8'h00);
      tick(3);
      rst = 1'b0;

      // Stable release, then a clean press of key 3 with out_ready low.
      tick(10);
      check("idle_valid", 8'(out_valid), 8'h00);
      key_in = 8'h08;
      tick(8);
      check("latency_edge7_valid", 8'(out_valid), 8'h00);
      tick(1);
      check("latency_edge8_valid", 8'(out_valid), 8'h01);
      check("capture_onehot", onehot_out, 8'h08);

      // Extra keys during HOLD must not disturb the held event.
      key_in = 8'h18;
      tick(10);
      check("hold_valid", 8'(out_valid), 8'h01);
      check("hold_onehot", onehot_out, 8'h08);
      check("hold_no_multi", 8'(multi_err), 8'h00);
      check("hold_count", press_count, 8'h00);
      key_in = 8'h08;
      tick(8);

      // Handshake; key still held afterwards gives no new event.
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      check("accept_valid", 8'(out_valid), 8'h00);
      check("accept_count", press_count, 8'h01);
      tick(20);
      check("held_no_recapture", 8'(out_valid), 8'h00);
      check("held_count", press_count, 8'h01);

      // Release with out_ready high: ready without valid is ignored.
      key_in    = 8'h00;
      out_ready = 1'b1;
      tick(10);
      out_ready = 1'b0;
      check("ready_ignored_count", press_count, 8'h01);
      check("ready_ignored_valid", 8'(out_valid), 8'h00);
      key_in = 8'h08;
      tick(9);
      check("repress_valid", 8'(out_valid), 8'h01);
      check("repress_onehot", onehot_out, 8'h08);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      check("repress_count", press_count, 8'h02);
      key_in = 8'h00;
      tick(10);

      // Two keys at once: one-cycle multi_err, nothing captured.
      key_in = 8'h41;
      tick(8);
      check("multi_before", 8'(multi_err), 8'h00);
      tick(1);
      check("multi_pulse", 8'(multi_err), 8'h01);
      check("multi_no_valid", 8'(out_valid), 8'h00);
      tick(1);
      check("multi_one_cycle", 8'(multi_err), 8'h00);
      tick(10);
      check("multi_no_repeat", 8'(multi_err), 8'h00);
      check("multi_onehot_kept", onehot_out, 8'h08);
      check("multi_count", press_count, 8'h02);
      key_in = 8'h00;
      tick(10);

      // Short glitch must be rejected.
      key_in = 8'h02;
      tick(3);
      key_in = 8'h00;
      seen   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (out_valid === 1'b1 || multi_err === 1'b1) seen = 1'b1;
      end
      check("glitch_rejected", 8'(seen), 8'h00);

      // 254 more accepted events bring the count from 2 through 255 to 0.
      for (int i = 0; i < 254; i++) begin
         exp    = one << (i % 8);
         key_in = exp;
         wait_valid(20);
         check("wrap_onehot", onehot_out, exp);
         out_ready = 1'b1;
         tick(1);
         out_ready = 1'b0;
         key_in    = 8'h00;
         tick(9);
         if (i == 252) check("wrap_count_ff", press_count, 8'hff);
      end
      check("wrap_count_00", press_count, 8'h00);

      // One more accepted event, then reset while the next one is pending.
      key_in = 8'h04;
      wait_valid(20);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      key_in    = 8'h00;
      tick(9);
      check("pre_reset_count", press_count, 8'h01);
      key_in = 8'h01;
      tick(9);
      check("pre_reset_valid", 8'(out_valid), 8'h01);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_onehot", onehot_out, 8'h00);
      check("async_rst_valid", 8'(out_valid), 8'h00);
      check("async_rst_count", press_count, 8'h00);
      #2;
      rst = 1'b0;
      tick(30);
      check("post_reset_held_ignored", 8'(out_valid), 8'h00);
      check("post_reset_no_multi", 8'(multi_err), 8'h00);
      key_in = 8'h00;
      tick(12);
      key_in = 8'h01;
      tick(9);
      check("post_reset_capture_valid", 8'(out_valid), 8'h01);
      check("post_reset_capture_onehot", onehot_out, 8'h01);
      check("post_reset_count", press_count, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/key_onehot_capture.md
KEY_ONEHOT_CAPTURE -- requirements
Module: key_onehot_capture

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16, number of consecutive unchanged synchronized samples that define a stable key vector (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 key_in  input  8  raw, asynchronous, active-high key/request lines; bit i = key i.
REQ-005 out_ready  input  1  downstream (one-hot encoder stage) accepts onehot_out this cycle.
REQ-006 onehot_out  output  8  captured key vector; exactly one bit set whenever out_valid=1.
REQ-007 out_valid  output  1  onehot_out holds an unconsumed press event.
REQ-008 multi_err  output  1  one-cycle pulse: a stable press had more than one bit set.
REQ-009 press_count  output  8  number of accepted (handshaken) press events, modulo 256.

Function
REQ-010 key_in SHALL pass through a 2-flop synchronizer per bit, giving vector s; p SHALL be s delayed one cycle.
REQ-011 Debounce counter cnt SHALL load 0 when s != p, else increment, saturating at DEBOUNCE_CYCLES; stable = (cnt == DEBOUNCE_CYCLES).
REQ-012 FSM states: WAIT_RELEASE, WAIT_PRESS, HOLD; reset state WAIT_RELEASE.
REQ-013 WAIT_RELEASE -> WAIT_PRESS when stable and p == 8'h00; otherwise remain.
REQ-014 WAIT_PRESS, stable and p has exactly one bit set: onehot_out <= p, out_valid <= 1, -> HOLD.
REQ-015 WAIT_PRESS, stable and p has two or more bits set: multi_err pulses 1 for exactly one cycle, onehot_out unchanged, -> WAIT_RELEASE.
REQ-016 WAIT_PRESS, stable and p == 0: remain.
REQ-017 HOLD: onehot_out and out_valid SHALL stay constant until out_valid && out_ready at a rising edge; on that edge out_valid <= 0, press_count <= press_count + 1 (wraps 255 -> 0), -> WAIT_RELEASE.
REQ-018 Key activity during HOLD SHALL NOT alter onehot_out; a key still held at handshake must be released (stable zero) before a new capture.
REQ-019 out_ready while out_valid = 0 SHALL be ignored.
REQ-020 Latency: a clean single-key press applied to key_in just before edge 0 (after stable release in WAIT_PRESS) SHALL produce out_valid = 1 after edge DEBOUNCE_CYCLES + 4.
REQ-021 Glitches shorter than DEBOUNCE_CYCLES + 1 synchronized cycles SHALL never produce out_valid or multi_err.
REQ-022 onehot_out SHALL be a registered output; no combinational path key_in -> outputs or out_ready -> outputs.

Reset
REQ-023 rst = 1 SHALL immediately (asynchronously) clear synchronizers, p, cnt, onehot_out = 8'h00, out_valid = 0, multi_err = 0, press_count = 8'h00, state = WAIT_RELEASE.
REQ-024 Reset asserted mid-HOLD SHALL drop the pending event without incrementing press_count.
REQ-025 After rst deasserts, no capture SHALL occur until a stable all-zero vector has been observed.

Structure
REQ-026 FSM state encodings (2 bits) and DEBOUNCE_CYCLES default SHALL live in shared package key_pkg.
REQ-027 Synchronizer plus debounce counter SHALL be one sub-module, vec_debounce (outputs p and stable); FSM, capture and press_count in the top.

Verification (DEBOUNCE_CYCLES = 4)
REQ-028 Reset, key_in = 0 for 10 cycles, then key_in = 8'h08 held, out_ready = 0 -> out_valid = 1, onehot_out = 8'h08 after edge 8, held constant.
REQ-029 From REQ-028 state, out_ready = 1 one cycle -> out_valid = 0 next edge, press_count = 1; key stays 8'h08 -> no new event until released stable then pressed again.
REQ-030 key_in = 8'h41 held -> multi_err one-cycle pulse, out_valid stays 0, press_count unchanged.
REQ-031 key_in = 8'h02 pulse of 3 cycles -> no out_valid, no multi_err.
REQ-032 256 accepted single-key events -> press_count wraps to 8'h00.
REQ-033 rst asserted mid-HOLD between edges -> outputs clear without a clock edge; after release, held key_in = 8'h01 not captured until released and re-pressed.
